dmc_dma_fetch: RTL and testbench

//  DMC sample-fetch controller: the upstream partner of the sprite DMA / address-bus arbiter.
//  It holds the DMC sample address and length counters, and fetches one byte per request

---
 rtl/dmc_dma_fetch.sv | 227 ++++++++++++++++++++++
 tb/tb_dmc_dma_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmc_dma_fetch.sv
// ---------------------------------------------------------------------------
// dmc_dma_fetch
//   DMC sample-fetch controller. Holds the sample address/length counters and
//   steals CPU cycles to fetch one sample byte each time the DMC output unit
//   reports an empty buffer. Drives the DMA arbiter (RUNDMC, n_DMCAB, DMCRDY,
//   DMC_Addr). One ACLK1 rising edge is one CPU cycle.
//
//   Optional feature macro: DMC_IRQ_EN
//     defined   : dmc_irq sets when the final byte is fetched with loop=0 and
//                 IRQ enable=1; cleared by any W4015 write or W4010 DB[7]=0.
//     undefined : dmc_irq is constant 0, W4010 DB[7] is ignored.
//
// Ports
//   ACLK1        in   clock, one rising edge per CPU cycle
//   n_RES        in   asynchronous active-low reset
//   W4010        in   write strobe: DB[7]=IRQ enable, DB[6]=loop
//   W4012        in   write strobe: sample address value
//   W4013        in   write strobe: sample length value
//   W4015        in   write strobe: DB[4]=DMC enable
//   DB[7:0]      in   data bus (register writes and fetched sample)
//   RnW          in   CPU cycle type, 1 = read (halt only lands on a read)
//   buf_empty    in   sample buffer empty (fetch request level)
//   RUNDMC       out  DMC DMA in progress
//   n_DMCAB      out  0 = DMC owns the address bus this cycle
//   DMCRDY       out  0 = hold the CPU
//   DMC_Addr     out  current sample address
//   sample_data  out  last fetched byte
//   sample_valid out  one-cycle pulse, sample_data is new
//   dmc_active   out  remaining length != 0
//   dmc_irq      out  DMC interrupt
// ---------------------------------------------------------------------------
module dmc_dma_fetch #(
    parameter logic [15:0] ADDR_BASE    = 16'hC000,
    parameter int          LEN_STEP     = 16,
    parameter int          ALIGN_CYCLES = 1
) (
    input  logic        ACLK1,
    input  logic        n_RES,
    input  logic        W4010,
    input  logic        W4012,
    input  logic        W4013,
    input  logic        W4015,
    input  logic [7:0]  DB,
    input  logic        RnW,
    input  logic        buf_empty,
    output logic        RUNDMC,
    output logic        n_DMCAB,
    output logic        DMCRDY,
    output logic [15:0] DMC_Addr,
    output logic [7:0]  sample_data,
    output logic        sample_valid,
    output logic        dmc_active,
    output logic        dmc_irq
);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_ALIGN, S_FETCH} state_t;

    localparam logic [1:0]  ALIGN_LAST = (ALIGN_CYCLES > 0) ? 2'(ALIGN_CYCLES - 1) : 2'd0;
    localparam logic [15:0] LEN_STEP_W = 16'(LEN_STEP);

    state_t      state_q, state_d;
    logic [1:0]  align_cnt_q, align_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  sdata_q, sdata_d;
    logic        svalid_q, svalid_d;
    logic        irq_q, irq_d;
    logic        loop_q;
    logic        irq_en_q;
    logic [7:0]  reg_addr_q;
    logic [7:0]  reg_len_q;

    logic [15:0] addr_inc;
    logic [15:0] reload_addr;
    logic [15:0] reload_len;
    logic        disable_wr;

    // Sample space lives in $8000-$FFFF: the increment wraps into $8000.
    assign addr_inc    = (addr_q == 16'hFFFF) ? 16'h8000 : addr_q + 16'd1;
    assign reload_addr = ADDR_BASE + 16'({reg_addr_q, 6'b0});
    assign reload_len  = 16'(reg_len_q * LEN_STEP_W) + 16'd1;
    assign disable_wr  = W4015 && !DB[4];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            state_q     <= S_IDLE;
            align_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        RUNDMC      = 1'b0;
        n_DMCAB     = 1'b1;
        DMCRDY      = 1'b1;
        case (state_q)
            S_IDLE: begin
                // The pending-valid term keeps the buffer-empty level from
                // re-requesting before the output unit has seen the byte.
                if (buf_empty && (len_q != 16'd0) && !svalid_q)
                    state_d = S_HALT;
            end
            S_HALT: begin
                RUNDMC = 1'b1;
                DMCRDY = 1'b0;
                // A disable before the halt has landed drops the request;
                // once past HALT the fetch always completes.
                if (disable_wr || (len_q == 16'd0)) begin
                    state_d = S_IDLE;
                end else if (RnW) begin
                    if (ALIGN_CYCLES == 0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d     = S_ALIGN;
                        align_cnt_d = ALIGN_LAST;
                    end
                end
            end
            S_ALIGN: begin
                RUNDMC = 1'b1;
                DMCRDY = 1'b0;
                if (align_cnt_q == 2'd0) state_d = S_FETCH;
                else                     align_cnt_d = align_cnt_q - 2'd1;
            end
            S_FETCH: begin
                RUNDMC  = 1'b1;
                DMCRDY  = 1'b0;
                n_DMCAB = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        sdata_d  = sdata_q;
        svalid_d = 1'b0;
        irq_d    = irq_q;

        if (state_q == S_FETCH) begin
            sdata_d  = DB;
            svalid_d = 1'b1;
            addr_d   = addr_inc;
            // Length may already be 0 if the DMC was disabled after HALT.
            if (len_q != 16'd0) len_d = len_q - 16'd1;
            if (len_q == 16'd1) begin
                if (loop_q) begin
                    // A same-cycle W4015 write overrides the loop reload.
                    if (!W4015) begin
                        addr_d = reload_addr;
                        len_d  = reload_len;
                    end
                end else if (irq_en_q) begin
                    irq_d = 1'b1;
                end
            end
        end

        if (W4015) begin
            irq_d = 1'b0;
            if (!DB[4]) begin
                len_d = 16'd0;
            end else if (len_d == 16'd0) begin
                addr_d = reload_addr;
                len_d  = reload_len;
            end
        end

        if (W4010 && !DB[7]) irq_d = 1'b0;
    end

    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            addr_q   <= ADDR_BASE;
            len_q    <= 16'd0;
            sdata_q  <= 8'd0;
            svalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            len_q    <= len_d;
            sdata_q  <= sdata_d;
            svalid_q <= svalid_d;
            irq_q    <= irq_d;
        end
    end

    // Stored register values, consumed only at the next reload.
    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            loop_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            reg_addr_q <= 8'd0;
            reg_len_q  <= 8'd0;
        end else begin
            if (W4010) begin
                loop_q <= DB[6];
`ifdef DMC_IRQ_EN
                irq_en_q <= DB[7];
`else
                irq_en_q <= 1'b0;
`endif
            end
            if (W4012) reg_addr_q <= DB;
            if (W4013) reg_len_q  <= DB;
        end
    end

    assign DMC_Addr     = addr_q;
    assign sample_data  = sdata_q;
    assign sample_valid = svalid_q;
    assign dmc_active   = (len_q != 16'd0);
`ifdef DMC_IRQ_EN
    assign dmc_irq      = irq_q;
`else
    assign dmc_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_dmc_dma_fetch.sv
// Directed bench for dmc_dma_fetch: reset, single fetch, write-cycle hold,
// address wrap, loop/disable, IRQ set/clear, reset mid-fetch.
module tb_dmc_dma_fetch;

`ifdef DMC_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        ACLK1 = 1'b0;
    logic        n_RES;
    logic        W4010, W4012, W4013, W4015;
    logic [7:0]  DB;
    logic        RnW, buf_empty;
    logic        RUNDMC, n_DMCAB, DMCRDY;
    logic [15:0] DMC_Addr;
    logic [7:0]  sample_data;
    logic        sample_valid, dmc_active, dmc_irq;

    int n_cmp = 0;
    int n_err = 0;

    dmc_dma_fetch dut (
        .ACLK1(ACLK1), .n_RES(n_RES),
        .W4010(W4010), .W4012(W4012), .W4013(W4013), .W4015(W4015),
        .DB(DB), .RnW(RnW), .buf_empty(buf_empty),
        .RUNDMC(RUNDMC), .n_DMCAB(n_DMCAB), .DMCRDY(DMCRDY),
        .DMC_Addr(DMC_Addr), .sample_data(sample_data),
        .sample_valid(sample_valid), .dmc_active(dmc_active), .dmc_irq(dmc_irq)
    );

    always #5 ACLK1 = ~ACLK1;

    task automatic step();
        @(posedge ACLK1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // which: 0=W4010 2=W4012 3=W4013 5=W4015
    task automatic wr(input int which, input logic [7:0] d);
        DB = d;
        W4010 = (which == 0);
        W4012 = (which == 2);
        W4013 = (which == 3);
        W4015 = (which == 5);
        step();
        W4010 = 0; W4012 = 0; W4013 = 0; W4015 = 0;
    endtask

    task automatic wait_fetch(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (n_DMCAB === 1'b0) break;
            step();
        end
        chk({tag, "_fetch_seen"}, 16'(n_DMCAB), 16'h0);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (RUNDMC === 1'b1) break;
            step();
        end
        chk({tag, "_halt_seen"}, 16'(RUNDMC), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_RES = 0; W4010 = 0; W4012 = 0; W4013 = 0; W4015 = 0;
        DB = 0; RnW = 1; buf_empty = 0;
        #12;
        // ---- reset state
        chk("rst_rundmc", 16'(RUNDMC), 16'h0);
        chk("rst_ndmcab", 16'(n_DMCAB), 16'h1);
        chk("rst_dmcrdy", 16'(DMCRDY), 16'h1);
        chk("rst_addr", DMC_Addr, 16'hC000);
        chk("rst_active", 16'(dmc_active), 16'h0);
        chk("rst_valid", 16'(sample_valid), 16'h0);
        chk("rst_irq", 16'(dmc_irq), 16'h0);
        n_RES = 1;
        step();
        buf_empty = 1;

        // ---- single fetch: C000 + 01<<6 = C040, length 0*16+1 = 1
        wr(2, 8'h01);
        wr(3, 8'h00);
        wr(5, 8'h10);
        chk("t2_addr", DMC_Addr, 16'hC040);
        chk("t2_active", 16'(dmc_active), 16'h1);
        chk("t2_idle_rundmc", 16'(RUNDMC), 16'h0);
        step();  // HALT
        chk("t2_halt_rundmc", 16'(RUNDMC), 16'h1);
        chk("t2_halt_dmcrdy", 16'(DMCRDY), 16'h0);
        chk("t2_halt_ndmcab", 16'(n_DMCAB), 16'h1);
        step();  // ALIGN
        chk("t2_align_ndmcab", 16'(n_DMCAB), 16'h1);
        chk("t2_align_dmcrdy", 16'(DMCRDY), 16'h0);
        step();  // FETCH
        chk("t2_fetch_ndmcab", 16'(n_DMCAB), 16'h0);
        chk("t2_fetch_addr", DMC_Addr, 16'hC040);
        DB = 8'hA5;
        step();
        chk("t2_valid", 16'(sample_valid), 16'h1);
        chk("t2_data", 16'(sample_data), 16'h00A5);
        chk("t2_dmcrdy_back", 16'(DMCRDY), 16'h1);
        chk("t2_active_off", 16'(dmc_active), 16'h0);
        chk("t2_addr_inc", DMC_Addr, 16'hC041);
        step();
        chk("t2_valid_pulse", 16'(sample_valid), 16'h0);
        chk("t2_stay_idle", 16'(RUNDMC), 16'h0);

        // ---- write-cycle hold in HALT
        RnW = 0;
        wr(5, 8'h10);
        step();  // HALT
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_dmcrdy", 16'(DMCRDY), 16'h0);
            chk("t3_hold_ndmcab", 16'(n_DMCAB), 16'h1);
            step();
        end
        chk("t3_still_halt", 16'(DMCRDY), 16'h0);
        RnW = 1;
        step();  // ALIGN
        chk("t3_align_ndmcab", 16'(n_DMCAB), 16'h1);
        chk("t3_align_rundmc", 16'(RUNDMC), 16'h1);
        step();  // FETCH
        chk("t3_fetch_ndmcab", 16'(n_DMCAB), 16'h0);
        DB = 8'h5A;
        step();
        chk("t3_data", 16'(sample_data), 16'h005A);
        chk("t3_addr", DMC_Addr, 16'hC041);

        // ---- wrap: C000 + FF<<6 = FFC0; length 4*16+1 = 65 bytes so the
        // sequence runs FFC0..FFFF (64 bytes) and then 8000.
        wr(2, 8'hFF);
        wr(3, 8'h04);
        wr(5, 8'h10);
        chk("t4_start", DMC_Addr, 16'hFFC0);
        for (int i = 0; i < 65; i++) begin
            logic [15:0] ea;
            ea = (i < 64) ? 16'(16'hFFC0 + i) : 16'h8000;
            wait_fetch("t4");
            chk("t4_addr", DMC_Addr, ea);
            DB = 8'(i);
            step();
            chk("t4_data", 16'(sample_data), 16'(i));
        end
        chk("t4_active_off", 16'(dmc_active), 16'h0);
        chk("t4_addr_end", DMC_Addr, 16'h8001);

        // ---- loop reload, then disable during ALIGN
        wr(0, 8'h40);
        wr(2, 8'h01);
        wr(3, 8'h00);
        wr(5, 8'h10);
        for (int k = 0; k < 2; k++) begin
            wait_fetch("t5");
            chk("t5_addr", DMC_Addr, 16'hC040);
            DB = 8'h11;
            step();
            chk("t5_data", 16'(sample_data), 16'h0011);
            chk("t5_reload_addr", DMC_Addr, 16'hC040);
            chk("t5_reload_active", 16'(dmc_active), 16'h1);
        end
        wait_halt("t5");
        step();  // ALIGN
        wr(5, 8'h00);  // disable during ALIGN, now in FETCH
        chk("t5_dis_fetch", 16'(n_DMCAB), 16'h0);
        chk("t5_dis_active", 16'(dmc_active), 16'h0);
        DB = 8'h77;
        step();
        chk("t5_dis_valid", 16'(sample_valid), 16'h1);
        chk("t5_dis_data", 16'(sample_data), 16'h0077);
        chk("t5_dis_addr", DMC_Addr, 16'hC041);
        chk("t5_dis_active2", 16'(dmc_active), 16'h0);

        // ---- IRQ
        wr(0, 8'h80);
        wr(5, 8'h10);   // len 0 -> reload C040, len 1
        wr(2, 8'hFF);   // affects only a later reload
        wr(5, 8'h10);   // len != 0 -> ignored
        wait_fetch("t6");
        chk("t6_addr_kept", DMC_Addr, 16'hC040);
        step();
        chk("t6_irq_set", 16'(dmc_irq), 16'(IRQ_ON));
        step();
        chk("t6_irq_sticky", 16'(dmc_irq), 16'(IRQ_ON));
        wr(5, 8'h00);
        chk("t6_irq_clr4015", 16'(dmc_irq), 16'h0);
        wr(2, 8'h01);
        wr(5, 8'h10);
        wait_fetch("t6b");
        step();
        chk("t6_irq_set2", 16'(dmc_irq), 16'(IRQ_ON));
        wr(0, 8'h00);
        chk("t6_irq_clr4010", 16'(dmc_irq), 16'h0);

        // ---- reset mid-FETCH
        wr(2, 8'hFF);
        wr(5, 8'h10);
        wait_fetch("t1");
        n_RES = 0;
        #1;
        chk("t1_ndmcab", 16'(n_DMCAB), 16'h1);
        chk("t1_dmcrdy", 16'(DMCRDY), 16'h1);
        chk("t1_rundmc", 16'(RUNDMC), 16'h0);
        chk("t1_addr", DMC_Addr, 16'hC000);
        chk("t1_data", 16'(sample_data), 16'h0);
        #2;
        n_RES = 1;
        step();
        chk("t1_no_valid", 16'(sample_valid), 16'h0);
        wr(5, 8'h10);   // stored regs cleared -> C000, length 1
        chk("t1_regs_addr", DMC_Addr, 16'hC000);
        chk("t1_regs_active", 16'(dmc_active), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
